// File: rtl/timer_count_up_pkg.sv
// Shared timer package: BCD digit geometry, nibble indices and
// the terminal-value test used by the up-counting stopwatch.
package timer_count_up_pkg;

    localparam int DIGIT_W = 4;
    localparam int SEC_U = 0;
    localparam int SEC_T = 1;
    localparam int MIN_U = 2;
    localparam int MIN_T = 3;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    // Clamp every nibble of a preset to a legal BCD digit.
    function automatic logic [15:0] bcd_clamp(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        for (int i = 0; i < 4; i++) begin
            if (v[i*4 +: 4] > BCD_MAX) begin
                r[i*4 +: 4] = BCD_MAX;
            end
        end
        return r;
    endfunction

    // Seconds-tens wraps at st_wrap, unless preset above it (then at 9).
    function automatic logic [3:0] sec_t_wrap(
        input logic [3:0] st,
        input logic [3:0] st_wrap
    );
        return (st <= st_wrap) ? st_wrap : BCD_MAX;
    endfunction

    function automatic logic is_term(
        input logic [15:0] c,
        input logic [3:0]  st_wrap
    );
        return (c[15:12] == BCD_MAX) && (c[11:8] == BCD_MAX) &&
               (c[7:4] == sec_t_wrap(c[7:4], st_wrap)) &&
               (c[3:0] == BCD_MAX);
    endfunction

endpackage

// File: rtl/timer_count_up_digit.sv
// bcd_digit_up: one BCD digit with preset, increment and wrap.
// Ports: clk, rst (sync, active-low), inc, load, d, wrap_val -> q, carry, at_wrap.
module bcd_digit_up
    import timer_count_up_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               inc,
    input  logic               load,
    input  logic [DIGIT_W-1:0] d,
    input  logic [DIGIT_W-1:0] wrap_val,
    output logic [DIGIT_W-1:0] q,
    output logic               carry,
    output logic               at_wrap
);

    logic [DIGIT_W-1:0] q_q;
    logic [DIGIT_W-1:0] q_d;

    assign q       = q_q;
    assign at_wrap = (q_q == wrap_val);
    assign carry   = inc && at_wrap;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = d;
        end else if (inc) begin
            q_d = at_wrap ? '0 : q_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

endmodule

// File: rtl/timer_count_up.sv
// Stopwatch MM:SS BCD up-counter with clamped preset, saturation at
// terminal value and registered active-low terminal flag rco_L.
// Ports: clk, rst (sync, active-low), en, load, din[15:0] -> count[15:0], rco_L.
module timer_count_up
    import timer_count_up_pkg::*;
#(
    parameter int SEC_TENS_WRAP = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] din,
    output logic [15:0] count,
    output logic        rco_L
);

    localparam logic [3:0] ST_WRAP = 4'(SEC_TENS_WRAP);

    logic [15:0] din_clamp;
    logic [3:0]  inc;
    logic [3:0]  carry;
    logic [3:0]  at_wrap;
    logic [3:0][3:0] wrap_val;
    logic [3:0][3:0] dig_q;
    logic        term_cur;
    logic        pre_term;
    logic        rco_L_q;
    logic        rco_L_d;
    logic        unused_carry;

    assign din_clamp = bcd_clamp(din);
    assign count     = dig_q;
    assign rco_L     = rco_L_q;

    assign term_cur = is_term(count, ST_WRAP);
    // One increment away from terminal: only sec_units 8 -> 9 changes.
    assign pre_term = (count[3:0] == 4'd8) &&
                      is_term({count[15:4], BCD_MAX}, ST_WRAP);

    assign wrap_val[SEC_U] = BCD_MAX;
    assign wrap_val[SEC_T] = sec_t_wrap(count[7:4], ST_WRAP);
    assign wrap_val[MIN_U] = BCD_MAX;
    assign wrap_val[MIN_T] = BCD_MAX;

    assign inc[SEC_U] = en && !load && !term_cur;
    assign inc[SEC_T] = carry[SEC_U];
    assign inc[MIN_U] = carry[SEC_T];
    assign inc[MIN_T] = carry[MIN_U];
    assign unused_carry = carry[MIN_T];

    for (genvar i = 0; i < 4; i++) begin : g_dig
        bcd_digit_up u_dig (
            .clk      (clk),
            .rst      (rst),
            .inc      (inc[i]),
            .load     (load),
            .d        (din_clamp[i*4 +: 4]),
            .wrap_val (wrap_val[i]),
            .q        (dig_q[i]),
            .carry    (carry[i]),
            .at_wrap  (at_wrap[i])
        );
    end

    // Flag follows the next-state count so it lines up with count.
    always_comb begin
        rco_L_d = !term_cur;
        if (load) begin
            rco_L_d = !is_term(din_clamp, ST_WRAP);
        end else if (inc[SEC_U] && pre_term) begin
            rco_L_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rco_L_q <= 1'b1;
        end else begin
            rco_L_q <= rco_L_d;
        end
    end

endmodule

// File: tb/tb_timer_count_up.sv
// Directed bench for timer_count_up: hand-computed MM:SS sequences,
// immediate assertions at each check, one summary line at the end.
module tb_timer_count_up;

    logic        clk;
    logic        rst;
    logic        en;
    logic        load;
    logic [15:0] din;
    logic [15:0] count;
    logic        rco_L;

    int checks = 0;
    int errors = 0;

    timer_count_up #(.SEC_TENS_WRAP(5)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .load  (load),
        .din   (din),
        .count (count),
        .rco_L (rco_L)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic r, input logic l,
                        input logic e, input logic [15:0] d);
        rst  = r;
        load = l;
        en   = e;
        din  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] exp_c,
                       input logic exp_r);
        checks++;
        assert (count === exp_c) else begin
            errors++;
            $error("FAIL %s count=%h expected=%h", tag, count, exp_c);
        end
        checks++;
        assert (rco_L === exp_r) else begin
            errors++;
            $error("FAIL %s rco_L=%b expected=%b", tag, rco_L, exp_r);
        end
    endtask

    initial begin
        rst = 1'b0; load = 1'b0; en = 1'b0; din = 16'h0;
        step(1'b0, 1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b1, 1'b1, 16'h4321);
        chk("reset", 16'h0000, 1'b1);

        for (int i = 0; i < 59; i++) begin
            step(1'b1, 1'b0, 1'b1, 16'h0);
            checks++;
            assert (rco_L === 1'b1) else begin
                errors++;
                $error("FAIL run60_rco rco_L=%b expected=1", rco_L);
            end
        end
        step(1'b1, 1'b0, 1'b1, 16'h0);
        chk("run60", 16'h0100, 1'b1);
        step(1'b1, 1'b0, 1'b0, 16'h0);
        chk("hold", 16'h0100, 1'b1);

        step(1'b1, 1'b1, 1'b0, 16'h0758);
        chk("ld0758", 16'h0758, 1'b1);
        step(1'b1, 1'b0, 1'b1, 16'h0);
        chk("0759", 16'h0759, 1'b1);
        step(1'b1, 1'b0, 1'b1, 16'h0);
        chk("0800", 16'h0800, 1'b1);

        step(1'b1, 1'b1, 1'b0, 16'h0297);
        chk("ld0297", 16'h0297, 1'b1);
        step(1'b1, 1'b0, 1'b1, 16'h0);
        chk("0298", 16'h0298, 1'b1);
        step(1'b1, 1'b0, 1'b1, 16'h0);
        chk("0299", 16'h0299, 1'b1);
        step(1'b1, 1'b0, 1'b1, 16'h0);
        chk("0300", 16'h0300, 1'b1);
        for (int i = 0; i < 60; i++) begin
            step(1'b1, 1'b0, 1'b1, 16'h0);
        end
        chk("0400", 16'h0400, 1'b1);

        step(1'b1, 1'b1, 1'b0, 16'h9958);
        chk("ld9958", 16'h9958, 1'b1);
        step(1'b1, 1'b0, 1'b1, 16'h0);
        chk("9959", 16'h9959, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b1, 16'h0);
        end
        chk("sat", 16'h9959, 1'b0);
        step(1'b1, 1'b1, 1'b0, 16'h0000);
        chk("ld0000", 16'h0000, 1'b1);

        step(1'b1, 1'b1, 1'b0, 16'h9999);
        chk("ld9999", 16'h9999, 1'b0);
        step(1'b1, 1'b0, 1'b1, 16'h0);
        chk("sat9999", 16'h9999, 1'b0);

        step(1'b1, 1'b1, 1'b1, 16'hFA3C);
        chk("clamp", 16'h9939, 1'b1);
        step(1'b1, 1'b0, 1'b1, 16'h0);
        chk("9940", 16'h9940, 1'b1);

        step(1'b1, 1'b1, 1'b0, 16'h1234);
        chk("ld1234", 16'h1234, 1'b1);
        step(1'b0, 1'b1, 1'b1, 16'h5555);
        chk("rstpri", 16'h0000, 1'b1);
        step(1'b1, 1'b0, 1'b1, 16'h0);
        chk("resume", 16'h0001, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
